// File: rtl/nibble_bus_pkg.sv
// Shared types and constants for the 4-bit nibble memory bus.
// Used by the far-end responder and by the wrapper-side requester.
package nibble_bus_pkg;

  localparam int unsigned NibbleW    = 4;
  localparam int unsigned NumNibbles = 8;
  localparam int unsigned ReqAddrW   = 8;

  typedef enum logic [2:0] {
    IDLE,
    WCOLLECT,
    WCOMMIT,
    RREQ,
    RCAPT,
    RSEND,
    RCOMMIT
  } rsp_state_e;

  typedef struct packed {
    logic [ReqAddrW-1:0] addr;
    logic [NibbleW-1:0]  data;
    logic                write;
    logic                strb;
  } nibble_req_t;

  // A byte is written only when both of its nibbles were strobed.
  function automatic logic [3:0] strb_to_be(input logic [NumNibbles-1:0] strb);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) begin
      be[i] = strb[2*i] & strb[2*i+1];
    end
    return be;
  endfunction

endpackage

// File: rtl/nibble_tx_serializer.sv
// Loads a 32-bit word and streams it MSB nibble first with valid/ready/last,
// followed by a fixed-length commit beat that ignores ready.
module nibble_tx_serializer
  import nibble_bus_pkg::*;
#(
  parameter int unsigned CommitCycles = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic [NibbleW*NumNibbles-1:0] load_data_i,
  output logic [NibbleW-1:0]            rsp_data_o,
  output logic                          rsp_valid_o,
  output logic                          rsp_last_o,
  input  logic                          rsp_ready_i,
  output logic                          last_hs_o,
  output logic                          done_o
);

  localparam int unsigned WordW      = NibbleW * NumNibbles;
  localparam logic [2:0]  LastCnt    = 3'(NumNibbles - 1);
  localparam logic [1:0]  LastCommit = 2'(CommitCycles - 1);

  logic [WordW-1:0] r_shift;
  logic [2:0]       r_cnt;
  logic [1:0]       r_ccnt;
  logic             r_send;
  logic             r_commit;
  logic             w_last_hs;
  logic             w_done;

  assign w_last_hs = r_send & rsp_ready_i & (r_cnt == LastCnt);
  assign w_done    = r_commit & (r_ccnt == LastCommit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_ccnt   <= '0;
      r_send   <= 1'b0;
      r_commit <= 1'b0;
    end else if (load_i) begin
      r_shift  <= load_data_i;
      r_cnt    <= '0;
      r_ccnt   <= '0;
      r_send   <= 1'b1;
      r_commit <= 1'b0;
    end else if (r_send && rsp_ready_i) begin
      r_shift <= {r_shift[WordW-NibbleW-1:0], {NibbleW{1'b0}}};
      if (r_cnt == LastCnt) begin
        r_send   <= 1'b0;
        r_commit <= 1'b1;
        r_ccnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end else if (r_commit) begin
      if (w_done) begin
        r_commit <= 1'b0;
      end else begin
        r_ccnt <= r_ccnt + 2'd1;
      end
    end
  end

  // The commit beat is a valid beat carrying zero data and no last.
  assign rsp_valid_o = r_send | r_commit;
  assign rsp_data_o  = r_send ? r_shift[WordW-1 -: NibbleW] : '0;
  assign rsp_last_o  = r_send & (r_cnt == LastCnt);
  assign last_hs_o   = w_last_hs;
  assign done_o      = w_done;

endmodule

// File: rtl/nibble_mem_responder.sv
// Far-end responder: collects nibble writes into SRAM words and serves
// single-word reads back as a nibble stream. One transaction at a time.
module nibble_mem_responder
  import nibble_bus_pkg::*;
#(
  parameter int unsigned AddrWidth    = 8,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned CommitCycles = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req_data_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic                 req_strb_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [3:0]           rsp_data_o,
  output logic                 rsp_valid_o,
  output logic                 rsp_last_o,
  input  logic                 rsp_ready_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam logic [2:0] LastCnt = 3'(NumNibbles - 1);

  rsp_state_e             r_state, w_state_d;
  logic [AddrWidth-1:0]   r_addr, w_addr_d;
  logic [DataWidth-1:0]   r_wdata, w_wdata_d;
  logic [NumNibbles-1:0]  r_strb, w_strb_d;
  logic [2:0]             r_cnt, w_cnt_d;

  logic                   r_mem_we;
  logic [AddrWidth-1:0]   r_mem_addr;
  logic [DataWidth-1:0]   r_mem_wdata;
  logic [3:0]             r_mem_be;

  nibble_req_t            w_req;
  logic                   w_load;
  logic                   w_last_hs;
  logic                   w_done;

  assign w_req.addr  = ReqAddrW'(req_addr_i);
  assign w_req.data  = req_data_i;
  assign w_req.write = req_write_i;
  assign w_req.strb  = req_strb_i;

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_wdata_d   = r_wdata;
    w_strb_d    = r_strb;
    w_cnt_d     = r_cnt;
    w_load      = 1'b0;
    req_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_addr_d = AddrWidth'(w_req.addr);
          if (w_req.write) begin
            w_wdata_d[NibbleW-1:0] = w_req.data;
            w_strb_d[0]            = w_req.strb;
            w_cnt_d                = 3'd1;
            w_state_d              = WCOLLECT;
          end else begin
            w_state_d = RREQ;
          end
        end
      end
      WCOLLECT: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_wdata_d[{r_cnt, 2'b00} +: NibbleW] = w_req.data;
          w_strb_d[r_cnt]                      = w_req.strb;
          if (r_cnt == LastCnt) begin
            w_state_d = WCOMMIT;
          end else begin
            w_cnt_d = r_cnt + 3'd1;
          end
        end
      end
      WCOMMIT: begin
        mem_req_o = 1'b1;
        w_state_d = IDLE;
      end
      RREQ: begin
        mem_req_o = 1'b1;
        w_state_d = RCAPT;
      end
      RCAPT: begin
        w_load    = 1'b1;
        w_state_d = RSEND;
      end
      RSEND: begin
        if (w_last_hs) w_state_d = RCOMMIT;
      end
      RCOMMIT: begin
        if (w_done) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_strb  <= w_strb_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // SRAM-side outputs are loaded on entry to an access state so they hold between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else if (r_state == WCOLLECT && w_state_d == WCOMMIT) begin
      r_mem_we    <= 1'b1;
      r_mem_addr  <= w_addr_d;
      r_mem_wdata <= w_wdata_d;
      r_mem_be    <= strb_to_be(w_strb_d);
    end else if (r_state == IDLE && w_state_d == RREQ) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= w_addr_d;
    end
  end

  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_be_o    = r_mem_be;

  nibble_tx_serializer #(
    .CommitCycles (CommitCycles)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (w_load),
    .load_data_i (mem_rdata_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_last_o  (rsp_last_o),
    .rsp_ready_i (rsp_ready_i),
    .last_hs_o   (w_last_hs),
    .done_o      (w_done)
  );

endmodule

// File: tb/tb_nibble_mem_responder.sv
// Self-checking bench: table vectors, randomized traffic against a word-level
// memory model, plus hand-written back-to-back and mid-transaction reset cases.
module tb_nibble_mem_responder;

  localparam int unsigned AW = 8;
  localparam int unsigned CC = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req_data_i = '0;
  logic [AW-1:0] req_addr_i = '0;
  logic          req_write_i = 1'b0;
  logic          req_strb_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [3:0]    rsp_data_o;
  logic          rsp_valid_o;
  logic          rsp_last_o;
  logic          rsp_ready_i = 1'b0;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_rdata_i = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_memreq = 0;

  always #5 clk = ~clk;

  nibble_mem_responder #(
    .AddrWidth    (AW),
    .DataWidth    (32),
    .CommitCycles (CC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_data_i  (req_data_i),
    .req_addr_i  (req_addr_i),
    .req_write_i (req_write_i),
    .req_strb_i  (req_strb_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_last_o  (rsp_last_o),
    .rsp_ready_i (rsp_ready_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Single-port SRAM with one-cycle read latency, byte enables on write.
  logic [31:0] sram [256] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_req_o) begin
      n_memreq <= n_memreq + 1;
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  // Reference memory updated from the intent of each completed write.
  logic [31:0] ref_mem [256] = '{default: 32'h0};

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  strb;
    int          mode;
    logic [3:0]  exp_be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] be_of(input logic [7:0] s);
    logic [3:0] be;
    for (int b = 0; b < 4; b++) be[b] = s[2*b] & s[2*b+1];
    return be;
  endfunction

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!req_ready_o && n < 64) begin
      tick();
      n++;
    end
    ok = req_ready_o;
    if (!ok) chk("req_ready_timeout", {31'b0, req_ready_o}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready_o}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid_o}, 32'd0);
    chk({tag, "_rsp_last"},  {31'b0, rsp_last_o},  32'd0);
    chk({tag, "_rsp_data"},  {28'b0, rsp_data_o},  32'd0);
    chk({tag, "_mem_req"},   {31'b0, mem_req_o},   32'd0);
    chk({tag, "_mem_we"},    {31'b0, mem_we_o},    32'd0);
    chk({tag, "_mem_addr"},  {24'b0, mem_addr_o},  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o,          32'd0);
    chk({tag, "_mem_be"},    {28'b0, mem_be_o},    32'd0);
  endtask

  // Sends a write; abort_k < 8 stops before beat abort_k is presented.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [7:0] strb, input logic [3:0] exp_be, input int abort_k);
    bit ok;
    for (int k = 0; k < 8; k++) begin
      if (k == abort_k) return;
      req_valid_i = 1'b1;
      req_data_i  = data[4*k +: 4];
      req_strb_i  = strb[k];
      if (k == 0) begin
        req_write_i = 1'b1;
        req_addr_i  = addr;
      end else begin
        req_write_i = 1'($urandom);
        req_addr_i  = 8'($urandom);
      end
      wait_ready(ok);
      if (!ok) return;
      tick();
      if (k < 7) chk("wr_collect_no_mem_req", {31'b0, mem_req_o}, 32'd0);
    end
    req_valid_i = 1'b0;
    chk("wr_mem_req",   {31'b0, mem_req_o},   32'd1);
    chk("wr_mem_we",    {31'b0, mem_we_o},    32'd1);
    chk("wr_mem_addr",  {24'b0, mem_addr_o},  {24'b0, addr});
    chk("wr_mem_wdata", mem_wdata_o,          data);
    chk("wr_mem_be",    {28'b0, mem_be_o},    {28'b0, exp_be});
    chk("wr_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("wr_commit_ready", {31'b0, req_ready_o}, 32'd0);
    tick();
    chk("wr_mem_req_drop", {31'b0, mem_req_o}, 32'd0);
    chk("wr_idle_ready",   {31'b0, req_ready_o}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      if (exp_be[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random.
  // abort_at < 8 returns while nibble abort_at is on the bus.
  // hold_wr presents a write's first beat for the whole read.
  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_word, input int mode,
                         input int abort_at, input bit hold_wr, input logic [7:0] waddr,
                         input logic [31:0] wdata);
    bit ok;
    int i = 0;
    int cyc = 0;
    bit r;
    logic [3:0] nib;
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = addr;
    req_data_i  = 4'($urandom);
    req_strb_i  = 1'($urandom);
    rsp_ready_i = 1'($urandom);
    wait_ready(ok);
    if (!ok) return;
    tick();
    if (hold_wr) begin
      req_write_i = 1'b1;
      req_addr_i  = waddr;
      req_data_i  = wdata[3:0];
      req_strb_i  = 1'b1;
    end else begin
      req_valid_i = 1'b0;
    end
    chk("rd_mem_req",   {31'b0, mem_req_o},   32'd1);
    chk("rd_mem_we",    {31'b0, mem_we_o},    32'd0);
    chk("rd_mem_addr",  {24'b0, mem_addr_o},  {24'b0, addr});
    chk("rd_req_ready", {31'b0, req_ready_o}, 32'd0);
    tick();
    chk("rd_capt_mem_req", {31'b0, mem_req_o},   32'd0);
    chk("rd_capt_valid",   {31'b0, rsp_valid_o}, 32'd0);
    chk("rd_capt_ready",   {31'b0, req_ready_o}, 32'd0);
    tick();
    while (i < 8 && cyc < 200) begin
      if (i == abort_at) return;
      nib = 4'((exp_word >> (28 - 4*i)) & 32'hF);
      chk("rd_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("rd_nibble", {28'b0, rsp_data_o}, {28'b0, nib});
      chk("rd_last", {31'b0, rsp_last_o}, (i == 7) ? 32'd1 : 32'd0);
      chk("rd_send_ready", {31'b0, req_ready_o}, 32'd0);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom);
      endcase
      rsp_ready_i = r;
      tick();
      cyc++;
      if (r) i++;
    end
    chk("rd_handshakes", i, 32'd8);
    for (int c = 0; c < CC; c++) begin
      chk("rd_commit_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("rd_commit_last",  {31'b0, rsp_last_o},  32'd0);
      chk("rd_commit_data",  {28'b0, rsp_data_o},  32'd0);
      chk("rd_commit_ready", {31'b0, req_ready_o}, 32'd0);
      rsp_ready_i = 1'($urandom);
      tick();
    end
    chk("rd_end_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rd_end_ready", {31'b0, req_ready_o}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic [7:0]  s;
    int          m0;
    logic [7:0]  addrs [5];
    addrs[0] = 8'h12; addrs[1] = 8'h34; addrs[2] = 8'h55; addrs[3] = 8'h00; addrs[4] = 8'hFF;

    tbl[0] = '{1'b1, 8'h12, 32'hDEADBEEF, 8'hFF, 0, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 8'h12, 32'h0,        8'h00, 0, 4'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 8'h12, 32'h12345678, 8'h0C, 0, 4'h2, 32'h0};
    tbl[3] = '{1'b0, 8'h12, 32'h0,        8'h00, 0, 4'h0, 32'hDEAD56EF};
    tbl[4] = '{1'b0, 8'h12, 32'h0,        8'h00, 1, 4'h0, 32'hDEAD56EF};
    tbl[5] = '{1'b1, 8'h34, 32'hCAFEF00D, 8'h3C, 0, 4'h6, 32'h0};
    tbl[6] = '{1'b0, 8'h34, 32'h0,        8'h00, 2, 4'h0, 32'h00FEF000};

    #1;
    chk_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 7; t++) begin
      if (tbl[t].is_wr) do_write(tbl[t].addr, tbl[t].data, tbl[t].strb, tbl[t].exp_be, 8);
      else do_read(tbl[t].addr, tbl[t].exp_rd, tbl[t].mode, 8, 1'b0, 8'h0, 32'h0);
    end

    for (int t = 0; t < 40; t++) begin
      a = addrs[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        do_write(a, d, s, be_of(s), 8);
      end else begin
        do_read(a, ref_mem[a], $urandom_range(0, 2), 8, 1'b0, 8'h0, 32'h0);
      end
    end

    // Read followed by a write held valid throughout the read.
    d = 32'hA5C3_1E7B;
    do_read(8'h12, ref_mem[8'h12], 0, 8, 1'b1, 8'h40, d);
    do_write(8'h40, d, 8'hFF, 4'hF, 8);
    do_read(8'h40, 32'hA5C3_1E7B, 1, 8, 1'b0, 8'h0, 32'h0);

    // Reset in the middle of write collection.
    do_write(8'h55, 32'h0BAD_F00D, 8'hFF, 4'hF, 4);
    m0 = n_memreq;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_wr");
    req_valid_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_wr_no_mem_req", n_memreq, m0);
    do_read(8'h55, ref_mem[8'h55], 0, 8, 1'b0, 8'h0, 32'h0);

    // Reset in the middle of response serialization.
    do_read(8'h12, ref_mem[8'h12], 0, 3, 1'b0, 8'h0, 32'h0);
    m0 = n_memreq;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_rd");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rd_no_mem_req", n_memreq, m0);
    do_write(8'h77, 32'h1357_9BDF, 8'hF0, 4'hC, 8);
    do_read(8'h77, 32'h1357_0000, 0, 8, 1'b0, 8'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
